// File: rtl/vga_scan_if.sv
// vga_scan_if: raster scan bundle from the scan generator to the sprite stage
//   pixel_tick  one-clk strobe per pixel
//   pixelx/y    current raster position (undelayed)
//   frame_start one-clk pulse after the counters wrap to (0,0)
//   hsync/vsync active-low syncs, delayed to match the sprite pipeline
//   video_on    active-area flag, delayed likewise
interface vga_scan_if;
  logic       pixel_tick;
  logic [9:0] pixelx;
  logic [9:0] pixely;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  modport master(output pixel_tick, pixelx, pixely, frame_start, hsync, vsync, video_on);
  modport slave(input pixel_tick, pixelx, pixely, frame_start, hsync, vsync, video_on);
endinterface

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: pixel-rate divider, raster counters and delayed sync/active decode
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   scan   vga_scan_if master: pixel_tick, pixelx, pixely, frame_start, hsync, vsync, video_on
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_scan_if.master scan
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  // 11-bit bounds so a sync pulse ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] div_cnt, div_nxt;
  logic [10:0] x, y;
  logic h_raw, v_raw, von_raw;
  always_comb begin
    div_nxt = div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
    x = {1'b0, scan.pixelx};
    y = {1'b0, scan.pixely};
    h_raw = !(x >= HS_BEG && x < HS_END);
    v_raw = !(y >= VS_BEG && y < VS_END);
    von_raw = x < H_ACT && y < V_ACT;
  end
  // tick is registered off the next divider value so it is high exactly while div_cnt==CLK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      scan.pixel_tick <= 1'b0;
      scan.pixelx <= '0;
      scan.pixely <= '0;
      scan.frame_start <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      scan.pixel_tick <= div_nxt == DIV_LAST;
      scan.frame_start <= scan.pixel_tick && scan.pixelx == H_LAST && scan.pixely == V_LAST;
      if (scan.pixel_tick) begin
        scan.pixelx <= scan.pixelx == H_LAST ? '0 : scan.pixelx + 1'b1;
        if (scan.pixelx == H_LAST) scan.pixely <= scan.pixely == V_LAST ? '0 : scan.pixely + 1'b1;
      end
    end
  end
  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign scan.hsync = h_raw;
      assign scan.vsync = v_raw;
      assign scan.video_on = von_raw;
    end else begin : g_dly
      // {hsync, vsync, video_on} per stage, advancing only on pixel ticks
      logic [2:0] dly [PIPE_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_LAT; i++) dly[i] <= 3'b110;
        end else if (scan.pixel_tick) begin
          dly[0] <= {h_raw, v_raw, von_raw};
          for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
      end
      assign {scan.hsync, scan.vsync, scan.video_on} = dly[PIPE_LAT-1];
    end
  endgenerate
endmodule
